// File: rtl/reg_dump_unit.sv
// Purpose: walks a wrapping range of a 4-entry register bank and streams (index, value) items with a running XOR checksum.
// Latency: one FETCH cycle plus at least one SEND cycle per item; done pulses one cycle after the last item is accepted.
// Backpressure: an item is held stable in SEND until out_ready is seen high at a clock edge; start is ignored while busy.
module reg_dump_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] first_reg,
    input  logic [1:0] last_reg,
    output logic [1:0] reg_read,
    input  logic [7:0] reg_data,
    output logic [7:0] out_data,
    output logic [1:0] out_index,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] index_q, index_d;
    logic [1:0] last_q, last_d;
    logic [7:0] data_q, data_d;
    logic [1:0] oidx_q, oidx_d;
    logic [7:0] csum_q, csum_d;

    // Next-state logic: range latch on start, one-cycle fetch, hold-until-accepted send.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        last_d  = last_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        csum_d  = csum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    index_d = first_reg;
                    last_d  = last_reg;
                    csum_d  = 8'h00;
                end
            end
            S_FETCH: begin
                // The bank read port is combinational, so the value is ready this cycle.
                data_d  = reg_data;
                oidx_d  = index_q;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    csum_d = csum_q ^ data_q;
                    if (index_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // 2-bit index wraps 3 -> 0, which gives wrapping ranges for free.
                        index_d = index_q + 2'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything, so an interrupted dump never resumes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            index_q <= 2'd0;
            last_q  <= 2'd0;
            data_q  <= 8'h00;
            oidx_q  <= 2'd0;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            last_q  <= last_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            csum_q  <= csum_d;
        end
    end

    assign reg_read  = index_q;
    assign out_data  = data_q;
    assign out_index = oidx_q;
    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign checksum  = csum_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
module tb_reg_dump_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] first_reg = 2'd0;
    logic [1:0] last_reg = 2'd0;
    logic [1:0] reg_read;
    logic [7:0] reg_data;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    logic [7:0] bank [4];
    assign reg_data = bank[reg_read];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    logic [9:0] log_q[$];
    int done_count = 0;

    reg_dump_unit dut (
        .clock(clock), .reset(reset), .start(start),
        .first_reg(first_reg), .last_reg(last_reg),
        .reg_read(reg_read), .reg_data(reg_data),
        .out_data(out_data), .out_index(out_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: a dump is N items at indices first+k (mod 4), each fetched then offered.
    logic       m_active, m_fetch, m_done;
    logic [2:0] m_k, m_n;
    logic [1:0] m_first, m_oi;
    logic [7:0] m_od, m_chk;
    wire  [1:0] m_cur    = m_first + m_k[1:0];
    wire  [1:0] rng_diff = last_reg - first_reg;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0; m_fetch <= 1'b0; m_done <= 1'b0;
            m_k <= 3'd0; m_n <= 3'd1; m_first <= 2'd0;
            m_od <= 8'h00; m_oi <= 2'd0; m_chk <= 8'h00;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1; m_fetch <= 1'b1; m_done <= 1'b0;
                m_k <= 3'd0; m_first <= first_reg;
                m_n <= {1'b0, rng_diff} + 3'd1;
                m_chk <= 8'h00;
            end
        end else if (m_done) begin
            m_active <= 1'b0; m_done <= 1'b0;
        end else if (m_fetch) begin
            m_od <= bank[m_cur]; m_oi <= m_cur; m_fetch <= 1'b0;
        end else if (out_ready) begin
            m_chk <= m_chk ^ m_od;
            if (m_k == m_n - 3'd1) m_done <= 1'b1;
            else begin
                m_k <= m_k + 3'd1;
                m_fetch <= 1'b1;
            end
        end
    end

    // Per-cycle compare of every output against the model, plus transfer/done logging.
    always @(negedge clock) begin
        if (cmp_en) begin
            logic [22:0] act, expv;
            act  = {reg_read, out_data, out_index, out_valid, busy, done, checksum};
            expv = {m_cur, m_od, m_oi, m_active && !m_fetch && !m_done, m_active, m_done, m_chk};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle_cmp at cycle %0d: got %h expected %h", cyc, act, expv);
            end
            if (reset && out_valid && out_ready) log_q.push_back({out_index, out_data});
            if (reset && done) done_count++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // mode 0: ready always; 1: stall 3 cycles on index 1; 2: random ready.
    task automatic run_dump(input logic [1:0] f, input logic [1:0] l, input int mode,
                            input bit mid_start, output int done_cyc, output int v1);
        int s, stalls;
        bit finished;
        log_q.delete();
        done_count = 0; stalls = 0; v1 = 0; finished = 0; done_cyc = -1;
        first_reg = f; last_reg = l; start = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        s = cyc; start = 1'b0;
        for (int i = 0; i < 80 && !finished; i++) begin
            if (mid_start && i == 2) begin
                start = 1'b1; first_reg = ~f; last_reg = f;
            end
            case (mode)
                1: begin
                    if (out_valid && out_index == 2'd1 && stalls < 3) begin
                        out_ready = 1'b0; stalls++;
                    end else out_ready = 1'b1;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_index == 2'd1) v1++;
            @(posedge clock); #1;
            start = 1'b0;
            if (done) begin
                finished = 1;
                done_cyc = cyc - s + 1;
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL dump_timeout: got no done expected done within 80 cycles");
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic chk_items(input string nm, input logic [9:0] e0, input logic [9:0] e1,
                             input logic [9:0] e2, input logic [9:0] e3, input int n);
        logic [9:0] ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        chk({nm, "_count"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) chk({nm, "_item"}, log_q[i], ex[i]);
    endtask

    initial begin
        int dc, v1, n_exp;
        logic [1:0] f, l, d;
        bank[0] = 8'hAA; bank[1] = 8'h55; bank[2] = 8'h0F; bank[3] = 8'hF0;

        #3 reset = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_reg_read", reg_read, 0);  chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0); chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_checksum", checksum, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Full range, free-flowing consumer.
        run_dump(2'd0, 2'd3, 0, 0, dc, v1);
        chk_items("full", {2'd0, 8'hAA}, {2'd1, 8'h55}, {2'd2, 8'h0F}, {2'd3, 8'hF0}, 4);
        chk("full_done_cycle", dc, 9); chk("full_checksum", checksum, 8'h00);
        chk("full_done_pulses", done_count, 1); chk("full_busy_after", busy, 0);

        // Wrapping range 3 -> 1.
        run_dump(2'd3, 2'd1, 0, 0, dc, v1);
        chk_items("wrap", {2'd3, 8'hF0}, {2'd0, 8'hAA}, {2'd1, 8'h55}, 10'd0, 3);
        chk("wrap_checksum", checksum, 8'h0F); chk("wrap_done_pulses", done_count, 1);
        chk("wrap_done_cycle", dc, 7);

        // Single register.
        run_dump(2'd2, 2'd2, 0, 0, dc, v1);
        chk_items("single", {2'd2, 8'h0F}, 10'd0, 10'd0, 10'd0, 1);
        chk("single_checksum", checksum, 8'h0F); chk("single_done_cycle", dc, 3);

        // Consumer stalls three cycles on R1.
        run_dump(2'd0, 2'd3, 1, 0, dc, v1);
        chk_items("stall", {2'd0, 8'hAA}, {2'd1, 8'h55}, {2'd2, 8'h0F}, {2'd3, 8'hF0}, 4);
        chk("stall_r1_valid_cycles", v1, 4); chk("stall_done_cycle", dc, 12);

        // A second start mid-dump is ignored.
        run_dump(2'd0, 2'd3, 0, 1, dc, v1);
        chk_items("midstart", {2'd0, 8'hAA}, {2'd1, 8'h55}, {2'd2, 8'h0F}, {2'd3, 8'hF0}, 4);
        chk("midstart_checksum", checksum, 8'h00); chk("midstart_done_cycle", dc, 9);

        // Reset asserted while R2 is on offer.
        first_reg = 2'd0; last_reg = 2'd3; start = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 0; i < 20 && !(out_valid && out_index == 2'd2); i++) begin
            @(posedge clock); #1;
        end
        chk("pre_reset_in_send_r2", {out_valid, out_index}, {1'b1, 2'd2});
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_reg_read", reg_read, 0); chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_index", out_index, 0); chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
        chk("mid_rst_checksum", checksum, 0);
        @(posedge clock); #1 reset = 1'b1;
        run_dump(2'd1, 2'd1, 0, 0, dc, v1);
        chk_items("post_rst", {2'd1, 8'h55}, 10'd0, 10'd0, 10'd0, 1);
        chk("post_rst_checksum", checksum, 8'h55); chk("post_rst_done_cycle", dc, 3);

        // Randomized dumps over random bank contents.
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 4; r++) bank[r] = 8'($urandom);
            f = 2'($urandom); l = 2'($urandom); d = l - f;
            n_exp = int'(d) + 1;
            run_dump(f, l, (t % 3 == 0) ? 0 : 2, 1'($urandom_range(0, 1)), dc, v1);
            chk("rand_count", log_q.size(), n_exp);
            chk("rand_done_pulses", done_count, 1);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 The module SHALL have one clock, clock; reset is asynchronous and active-low, named reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a dump; sampled only in IDLE.
REQ-005 first_reg  input  2  first register index of the range; latched on an accepted start.
REQ-006 last_reg  input  2  last register index of the range; latched on an accepted start.
REQ-007 reg_read  output  2  read address driven to the register bank's read port 1.
REQ-008 reg_data  input  8  combinational read data returned by the register bank for reg_read.
REQ-009 out_data  output  8  dumped register value.
REQ-010 out_index  output  2  register index of out_data.
REQ-011 out_valid  output  1  out_data and out_index are valid.
REQ-012 out_ready  input  1  consumer accepts the current item.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last item is accepted.
REQ-015 checksum  output  8  XOR of all bytes accepted in the current or most recent dump.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SEND and DONE.
REQ-017 IDLE with start=1 at an edge: latch the range, set the index to first_reg, clear checksum to 0x00, go to FETCH.
REQ-018 FETCH lasts exactly one cycle: reg_read = index; at the closing edge capture reg_data into out_data, index into out_index, then go to SEND.
REQ-019 SEND: out_valid=1; out_data and out_index SHALL hold stable until out_valid and out_ready are both high at an edge.
REQ-020 On transfer: checksum ^= out_data; out_valid drops the next cycle. If index == last, go to DONE; otherwise index = index+1 mod 4 and go to FETCH.
REQ-021 DONE lasts one cycle with done=1, then returns to IDLE; checksum holds until the next accepted start.
REQ-022 Item count SHALL be ((last_reg - first_reg) mod 4) + 1; index wraps 3->0; first_reg == last_reg dumps exactly one register.
REQ-023 start SHALL be ignored outside IDLE; first_reg and last_reg changes after acceptance SHALL have no effect.
REQ-024 With out_ready held at 1, each item SHALL take 2 cycles (FETCH + SEND); done SHALL assert in cycle 2N+1 after the start edge.
REQ-025 reg_read SHALL equal the current index in all states; busy SHALL be 0 only in IDLE.
REQ-026 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-027 reset low SHALL immediately force state IDLE, index 0 and all outputs to 0 (reg_read, out_data, out_index, out_valid, busy, done, checksum), including in the middle of a dump.
REQ-028 The first start SHALL be accepted at the first rising edge after reset goes high; no partial dump SHALL resume.

Verification
Bank preloaded with R0=0xAA, R1=0x55, R2=0x0F, R3=0xF0 for all scenarios.
REQ-029 first=0, last=3, out_ready=1 -> items (0,AA), (1,55), (2,0F), (3,F0); done in cycle 9; checksum 0x00; busy 0 afterwards.
REQ-030 first=3, last=1 (wrap) -> items (3,F0), (0,AA), (1,55); checksum 0x0F; one done pulse.
REQ-031 first=last=2 -> single item (2,0F); checksum 0x0F; done in cycle 3.
REQ-032 out_ready low for 3 cycles during the item for R1 -> out_valid, out_data=0x55 and out_index=1 stay stable; the item transfers on the first edge with out_ready high; no item is duplicated or lost.
REQ-033 start pulsed again mid-dump with a different range -> ignored; the original sequence and checksum are unchanged.
REQ-034 reset low during SEND of R2 -> all outputs 0 asynchronously; after release, start with first=1, last=1 -> single item (1,55), checksum 0x55.
